// File: rtl/sp_dma_pkg.sv
// Shared definitions for the sp_dma_seq block: default widths and the
// sequencer state encoding.
package sp_dma_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 9;
  localparam int ROW_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/sp_dma_addr_ctr.sv
// Address / beat / row bookkeeping for the DMA sequencer.
// Holds the current beat address (select bit plus offset), the beats left in
// the current row and the rows left in the transfer. The offset wraps inside
// its memory; the select bit is only written on load.
module sp_dma_addr_ctr
  import sp_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              load,
  input  logic              beat_step,
  input  logic              row_step,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [ROW_W-1:0]  count_in,
  input  logic [LEN_W-1:0]  skip_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              beat_zero,
  output logic              rows_zero
);

  localparam int OFF_W = ADDR_W - 1;

  logic              sel_q;
  logic [OFF_W-1:0]  off_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  len_q;
  logic [ROW_W-1:0]  row_q;
  logic [LEN_W-1:0]  skip_q;

  // Load on start, step one beat, or jump to the next row.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sel_q  <= 1'b0;
      off_q  <= '0;
      beat_q <= '0;
      len_q  <= '0;
      row_q  <= '0;
      skip_q <= '0;
    end else if (load) begin
      sel_q  <= addr_in[ADDR_W-1];
      off_q  <= addr_in[OFF_W-1:0];
      beat_q <= len_in;
      len_q  <= len_in;
      row_q  <= count_in;
      skip_q <= skip_in;
    end else if (beat_step) begin
      off_q  <= off_q + OFF_W'(1);
      beat_q <= beat_q - LEN_W'(1);
    end else if (row_step) begin
      // Offset sits on the last beat of the row, so skip+1 lands on the
      // first beat of the next row; the sum wraps at the offset width.
      off_q  <= off_q + OFF_W'(skip_q) + OFF_W'(1);
      beat_q <= len_q;
      row_q  <= row_q - ROW_W'(1);
    end
  end

  assign mem_addr  = {sel_q, off_q};
  assign beat_zero = (beat_q == '0);
  assign rows_zero = (row_q == '0);

endmodule

// File: rtl/sp_dma_seq.sv
// DMA address sequencer: walks a run of double-word beats (optionally several
// rows separated by a skip) through a valid/ack handshake.
// Build option: SP_DMA_SEQ_ROWS_EN enables multi-row transfers (count_in,
// skip_in and the GAP state). Without it every transfer is a single row.
module sp_dma_seq
  import sp_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LEN_W-1:0]  len_in,
`ifdef SP_DMA_SEQ_ROWS_EN
  input  logic [ROW_W-1:0]  count_in,
  input  logic [LEN_W-1:0]  skip_in,
`endif
  input  logic              xfer_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              xfer_valid,
  output logic              busy,
  output logic              done
);

  dma_state_e state_q, state_d;
  logic       load, beat_step, row_step;
  logic       beat_zero, rows_zero;
  logic [ROW_W-1:0] count_w;
  logic [LEN_W-1:0] skip_w;

`ifdef SP_DMA_SEQ_ROWS_EN
  assign count_w = count_in;
  assign skip_w  = skip_in;
`else
  // A zero row count keeps rows_zero high, so the FSM never enters GAP.
  assign count_w = '0;
  assign skip_w  = '0;
`endif

  sp_dma_addr_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_ctr (
    .clk       (clk),
    .reset_l   (reset_l),
    .load      (load),
    .beat_step (beat_step),
    .row_step  (row_step),
    .addr_in   (addr_in),
    .len_in    (len_in),
    .count_in  (count_w),
    .skip_in   (skip_w),
    .mem_addr  (mem_addr),
    .beat_zero (beat_zero),
    .rows_zero (rows_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and counter control; abort overrides everything.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    beat_step = 1'b0;
    row_step  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            load    = 1'b1;
            state_d = XFER;
          end
        end
        XFER: begin
          if (xfer_ack) begin
            if (!beat_zero) beat_step = 1'b1;
            else            state_d   = rows_zero ? DONE : GAP;
          end
        end
        GAP: begin
          row_step = 1'b1;
          state_d  = XFER;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign xfer_valid = (state_q == XFER);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule
